// File: rtl/snn_layer_sequencer.sv
// Control sequencer for a two-layer SNN inference: walks the input->hidden and
// hidden->output MAC passes over a shared MAC/LUT and reports the argmax digit.
module snn_layer_sequencer #(
    parameter int unsigned N_IN  = 784,
    parameter int unsigned N_HID = 32,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned LUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [9:0]       addr_input_unit,
    output logic [14:0]      addr_hid_weight,
    output logic [8:0]       addr_out_weight,
    output logic [4:0]       addr_hidden_unit,
    output logic             hid_we,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             mac_sel,
    output logic             lut_rd,
    input  logic [LUT_W-1:0] lut_q,
    output logic [3:0]       digit,
    output logic             done
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_HID_MAC = 4'd1;
    localparam logic [3:0] S_HID_DR1 = 4'd2;
    localparam logic [3:0] S_HID_DR2 = 4'd3;
    localparam logic [3:0] S_HID_WR  = 4'd4;
    localparam logic [3:0] S_OUT_MAC = 4'd5;
    localparam logic [3:0] S_OUT_DR1 = 4'd6;
    localparam logic [3:0] S_OUT_DR2 = 4'd7;
    localparam logic [3:0] S_OUT_CMP = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;

    localparam logic [9:0] IN_LAST  = 10'(N_IN - 1);
    localparam logic [4:0] HID_LAST = 5'(N_HID - 1);
    localparam logic [3:0] OUT_LAST = 4'(N_OUT - 1);

    logic [3:0]       state_q,   state_d;
    logic [9:0]       in_addr_q, in_addr_d;
    logic [14:0]      hw_addr_q, hw_addr_d;
    logic [8:0]       ow_addr_q, ow_addr_d;
    logic [4:0]       hu_addr_q, hu_addr_d;
    logic [4:0]       j_q,       j_d;
    logic [3:0]       o_q,       o_d;
    logic [3:0]       digit_q,   digit_d;
    logic [LUT_W-1:0] best_q,    best_d;
    logic             done_q,    done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_addr_q <= '0;
            hw_addr_q <= '0;
            ow_addr_q <= '0;
            hu_addr_q <= '0;
            j_q       <= '0;
            o_q       <= '0;
            digit_q   <= '0;
            best_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_addr_q <= in_addr_d;
            hw_addr_q <= hw_addr_d;
            ow_addr_q <= ow_addr_d;
            hu_addr_q <= hu_addr_d;
            j_q       <= j_d;
            o_q       <= o_d;
            digit_q   <= digit_d;
            best_q    <= best_d;
            done_q    <= done_d;
        end
    end

    // The input-unit address doubles as k in the hidden layer and the
    // hidden-unit address doubles as k in the output layer; weight addresses
    // are running counters that only advance while a new operand is fetched.
    always_comb begin
        state_d   = state_q;
        in_addr_d = in_addr_q;
        hw_addr_d = hw_addr_q;
        ow_addr_d = ow_addr_q;
        hu_addr_d = hu_addr_q;
        j_d       = j_q;
        o_d       = o_q;
        digit_d   = digit_q;
        best_d    = best_q;
        done_d    = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_HID_MAC;
                    in_addr_d = '0;
                    hw_addr_d = '0;
                    ow_addr_d = '0;
                    hu_addr_d = '0;
                    j_d       = '0;
                    o_d       = '0;
                    digit_d   = '0;
                    best_d    = '0;
                    done_d    = 1'b0;
                end
            end
            S_HID_MAC: begin
                if (in_addr_q == IN_LAST) begin
                    state_d = S_HID_DR1;
                end else begin
                    in_addr_d = in_addr_q + 10'd1;
                    hw_addr_d = hw_addr_q + 15'd1;
                end
            end
            S_HID_DR1: state_d = S_HID_DR2;
            S_HID_DR2: begin
                state_d   = S_HID_WR;
                hu_addr_d = j_q;
            end
            S_HID_WR: begin
                if (j_q == HID_LAST) begin
                    state_d   = S_OUT_MAC;
                    hu_addr_d = '0;
                end else begin
                    state_d   = S_HID_MAC;
                    j_d       = j_q + 5'd1;
                    in_addr_d = '0;
                    hw_addr_d = hw_addr_q + 15'd1;
                end
            end
            S_OUT_MAC: begin
                if (hu_addr_q == HID_LAST) begin
                    state_d = S_OUT_DR1;
                end else begin
                    hu_addr_d = hu_addr_q + 5'd1;
                    ow_addr_d = ow_addr_q + 9'd1;
                end
            end
            S_OUT_DR1: state_d = S_OUT_DR2;
            S_OUT_DR2: state_d = S_OUT_CMP;
            S_OUT_CMP: begin
                if ((o_q == 4'd0) || (lut_q > best_q)) begin
                    best_d  = lut_q;
                    digit_d = o_q;
                end
                if (o_q == OUT_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_OUT_MAC;
                    o_d       = o_q + 4'd1;
                    hu_addr_d = '0;
                    ow_addr_d = ow_addr_q + 9'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // mac_en trails the address by one cycle because memory reads are synchronous.
    always_comb begin
        mac_clr = ((state_q == S_HID_MAC) && (in_addr_q == '0)) ||
                  ((state_q == S_OUT_MAC) && (hu_addr_q == '0));
        mac_en  = ((state_q == S_HID_MAC) && (in_addr_q != '0)) ||
                  ((state_q == S_OUT_MAC) && (hu_addr_q != '0)) ||
                  (state_q == S_HID_DR1) || (state_q == S_OUT_DR1);
        mac_sel = (state_q == S_OUT_MAC) || (state_q == S_OUT_DR1) ||
                  (state_q == S_OUT_DR2);
        lut_rd  = (state_q == S_HID_DR2) || (state_q == S_OUT_DR2);
        hid_we  = (state_q == S_HID_WR);
    end

    assign addr_input_unit  = in_addr_q;
    assign addr_hid_weight  = hw_addr_q;
    assign addr_out_weight  = ow_addr_q;
    assign addr_hidden_unit = hu_addr_q;
    assign digit            = digit_q;
    assign done             = done_q;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Bench for snn_layer_sequencer: small-parameter instance for timing/sequence
// checks against a queue-based model, plus a default-size instance for the full run.
module tb_snn_layer_sequencer;

    localparam int S_IN = 4, S_HID = 2, S_OUT = 3;
    localparam int S_EDGES = S_HID * (S_IN + 3) + S_OUT * (S_HID + 3);
    localparam int D_EDGES = 32 * (784 + 3) + 10 * (32 + 3);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic       start = 1'b0;
    logic [9:0] addr_input_unit;
    logic [14:0] addr_hid_weight;
    logic [8:0] addr_out_weight;
    logic [4:0] addr_hidden_unit;
    logic       hid_we, mac_clr, mac_en, mac_sel, lut_rd, done;
    logic [7:0] lut_q = '0;
    logic [3:0] digit;

    snn_layer_sequencer #(.N_IN(S_IN), .N_HID(S_HID), .N_OUT(S_OUT), .LUT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start),
        .addr_input_unit(addr_input_unit), .addr_hid_weight(addr_hid_weight),
        .addr_out_weight(addr_out_weight), .addr_hidden_unit(addr_hidden_unit),
        .hid_we(hid_we), .mac_clr(mac_clr), .mac_en(mac_en), .mac_sel(mac_sel),
        .lut_rd(lut_rd), .lut_q(lut_q), .digit(digit), .done(done)
    );

    // default-size instance
    logic       start_d = 1'b0;
    logic [9:0] addr_input_unit_d;
    logic [14:0] addr_hid_weight_d;
    logic [8:0] addr_out_weight_d;
    logic [4:0] addr_hidden_unit_d;
    logic       hid_we_d, mac_clr_d, mac_en_d, mac_sel_d, lut_rd_d, done_d;
    logic [7:0] lut_q_d = '0;
    logic [3:0] digit_d;

    snn_layer_sequencer dut_d (
        .clk(clk), .rst_n(rst_n), .start(start_d),
        .addr_input_unit(addr_input_unit_d), .addr_hid_weight(addr_hid_weight_d),
        .addr_out_weight(addr_out_weight_d), .addr_hidden_unit(addr_hidden_unit_d),
        .hid_we(hid_we_d), .mac_clr(mac_clr_d), .mac_en(mac_en_d), .mac_sel(mac_sel_d),
        .lut_rd(lut_rd_d), .lut_q(lut_q_d), .digit(digit_d), .done(done_d)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Synchronous LUT model: output-layer reads return the scripted values in order.
    logic [7:0] out_vals [0:15];
    logic [7:0] dvals [0:15];
    int rd_idx = 0;
    int drd_idx = 0;

    always @(posedge clk) begin
        if (lut_rd) begin
            if (mac_sel) begin
                lut_q <= out_vals[rd_idx & 15];
                rd_idx++;
            end else begin
                lut_q <= 8'($urandom);
            end
        end
        if (lut_rd_d) begin
            if (mac_sel_d) begin
                lut_q_d <= dvals[drd_idx & 15];
                drd_idx++;
            end else begin
                lut_q_d <= 8'($urandom);
            end
        end
    end

    // Observation of the small instance during a run.
    logic mon_en = 1'b0;
    int hw_q[$];
    int ow_q[$];
    int we_q[$];
    int n_clr, n_en, n_rd, n_bad;

    always @(negedge clk) begin
        if (mon_en) begin
            if (hw_q.size() == 0 || hw_q[$] != int'(addr_hid_weight)) hw_q.push_back(int'(addr_hid_weight));
            if (ow_q.size() == 0 || ow_q[$] != int'(addr_out_weight)) ow_q.push_back(int'(addr_out_weight));
            if (mac_clr) n_clr++;
            if (mac_en) n_en++;
            if (lut_rd) n_rd++;
            if (hid_we) begin
                we_q.push_back(int'(addr_hidden_unit));
                if (mac_sel) n_bad++;
            end
            if ($countones({mac_clr, mac_en, lut_rd, hid_we}) > 1) n_bad++;
        end
    end

    function automatic int ref_argmax(input int n);
        int best_i = 0;
        for (int i = 1; i < n; i++)
            if (out_vals[i] > out_vals[best_i]) best_i = i;
        return best_i;
    endfunction

    task automatic do_run(input int busy_at, input int limit, output int edges);
        edges = 0;
        rd_idx = 0;
        hw_q.delete(); ow_q.delete(); we_q.delete();
        n_clr = 0; n_en = 0; n_rd = 0; n_bad = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mon_en = 1'b1;
        check("done_low_after_start", {31'd0, done}, 32'd0);
        while (!done && edges < limit) begin
            @(posedge clk);
            edges++;
            #1;
            start = (edges == busy_at);
        end
        start = 1'b0;
        mon_en = 1'b0;
    endtask

    task automatic verify_run(input string tag, input int edges);
        int exp_digit;
        exp_digit = ref_argmax(S_OUT);
        check({tag, "_edges"}, edges, S_EDGES);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_digit"}, {28'd0, digit}, exp_digit);
        check({tag, "_hw_len"}, hw_q.size(), S_HID * S_IN);
        for (int i = 0; i < S_HID * S_IN; i++)
            check($sformatf("%s_hw%0d", tag, i), (i < hw_q.size()) ? hw_q[i] : -1, i);
        check({tag, "_ow_len"}, ow_q.size(), S_OUT * S_HID);
        for (int i = 0; i < S_OUT * S_HID; i++)
            check($sformatf("%s_ow%0d", tag, i), (i < ow_q.size()) ? ow_q[i] : -1, i);
        check({tag, "_we_len"}, we_q.size(), S_HID);
        for (int i = 0; i < S_HID; i++)
            check($sformatf("%s_we%0d", tag, i), (i < we_q.size()) ? we_q[i] : -1, i);
        check({tag, "_n_clr"}, n_clr, S_HID + S_OUT);
        check({tag, "_n_en"}, n_en, S_HID * S_IN + S_OUT * S_HID);
        check({tag, "_n_rd"}, n_rd, S_HID + S_OUT);
        check({tag, "_strobe_rules"}, n_bad, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ain"}, {22'd0, addr_input_unit}, 0);
        check({tag, "_ahw"}, {17'd0, addr_hid_weight}, 0);
        check({tag, "_aow"}, {23'd0, addr_out_weight}, 0);
        check({tag, "_ahu"}, {27'd0, addr_hidden_unit}, 0);
        check({tag, "_strobes"}, {27'd0, hid_we, mac_clr, mac_en, mac_sel, lut_rd}, 0);
        check({tag, "_digit"}, {28'd0, digit}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
    endtask

    initial begin
        int edges;
        int cnt;

        // reset with start held high
        rst_n = 1'b0;
        start = 1'b1;
        start_d = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        check("reset_d_done", {31'd0, done_d}, 0);
        check("reset_d_strobes", {27'd0, hid_we_d, mac_clr_d, mac_en_d, mac_sel_d, lut_rd_d}, 0);
        start = 1'b0;
        start_d = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // argmax with a tie: lowest index wins
        out_vals[0] = 8'd10; out_vals[1] = 8'd50; out_vals[2] = 8'd50;
        do_run(-1, 200, edges);
        verify_run("tie", edges);
        check("tie_digit_const", {28'd0, digit}, 1);

        // all-zero LUT outputs
        out_vals[0] = 8'd0; out_vals[1] = 8'd0; out_vals[2] = 8'd0;
        do_run(-1, 200, edges);
        verify_run("zeros", edges);

        // start re-pulsed during the hidden layer is ignored
        for (int i = 0; i < S_OUT; i++) out_vals[i] = 8'($urandom);
        do_run(3, 200, edges);
        verify_run("busy", edges);

        // ends in DONE with digit 2, then restart from DONE
        out_vals[0] = 8'd1; out_vals[1] = 8'd2; out_vals[2] = 8'd9;
        do_run(-1, 200, edges);
        verify_run("pre_restart", edges);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < S_OUT; i++) out_vals[i] = 8'($urandom_range(0, 7));
            do_run(-1, 200, edges);
            verify_run($sformatf("restart%0d", r), edges);
        end

        // reset during the output layer, then a fresh run
        for (int i = 0; i < S_OUT; i++) out_vals[i] = 8'hFF;
        rd_idx = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!mac_sel && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_out_mac", {31'd0, mac_sel}, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        out_vals[0] = 8'd3; out_vals[1] = 8'd1; out_vals[2] = 8'd2;
        do_run(-1, 200, edges);
        verify_run("after_reset", edges);

        // full default-size inference
        for (int i = 0; i < 10; i++) dvals[i] = 8'($urandom);
        drd_idx = 0;
        @(negedge clk);
        start_d = 1'b1;
        @(posedge clk);
        #1;
        start_d = 1'b0;
        edges = 0;
        while (!done_d && edges < D_EDGES + 100) begin
            @(posedge clk);
            edges++;
            #1;
        end
        begin
            int bi = 0;
            for (int i = 1; i < 10; i++) if (dvals[i] > dvals[bi]) bi = i;
            check("dflt_edges", edges, D_EDGES);
            check("dflt_edges_const", edges, 25534);
            check("dflt_done", {31'd0, done_d}, 1);
            check("dflt_digit", {28'd0, digit_d}, bi);
            check("dflt_hw_end", {17'd0, addr_hid_weight_d}, 25087);
            check("dflt_ow_end", {23'd0, addr_out_weight_d}, 319);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
